// File: rtl/dkong_hs_pkg.sv
// Shared types and constants for the Donkey Kong high-score transfer block.
package dkong_hs_pkg;

   typedef enum logic [2:0] {
      IDLE,
      POLL,
      VERIFY,
      RESTORE,
      READY,
      SAVE
   } state_t;

   typedef enum logic [1:0] {
      B_IDLE,
      B_GUARD,
      B_ACTIVE,
      B_DROP
   } br_state_t;

   // Read latencies of the external buffer and of the core hs port.
   localparam int BUF_LAT = 1;
   localparam int HS_LAT  = 2;

   localparam logic [15:0] DEF_START_ADDR  = 16'h6100;
   localparam int          DEF_LENGTH      = 64;
   localparam logic [15:0] DEF_CHECK_ADDR  = 16'h611C;
   localparam logic [7:0]  DEF_CHECK_VAL   = 8'h00;
   localparam int          DEF_WAIT_FRAMES = 4;
   localparam int          DEF_GUARD       = 8;

   function automatic logic [15:0] hs_addr(input logic [15:0] base, input logic [7:0] idx);
      return base + {8'h00, idx};
   endfunction

endpackage

// File: rtl/dkong_hs_bracket.sv
// Pause/guard/access sequencer: raises pause, waits GUARD cycles, raises access
// until done, then drops access and, one cycle later, pause; fin pulses then.
module dkong_hs_bracket
   import dkong_hs_pkg::*;
#(
   parameter int GUARD = DEF_GUARD
)(
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic done,
   output logic pause,
   output logic access,
   output logic fin
);

   localparam int CW = $clog2(GUARD + 1);

   br_state_t       state;
   logic [CW-1:0]   cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= B_IDLE;
         cnt    <= '0;
         pause  <= 1'b0;
         access <= 1'b0;
         fin    <= 1'b0;
      end else begin
         fin <= 1'b0;
         case (state)
            B_IDLE: begin
               if (start) begin
                  pause <= 1'b1;
                  cnt   <= '0;
                  state <= B_GUARD;
               end
            end
            B_GUARD: begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(GUARD - 1)) begin
                  access <= 1'b1;
                  state  <= B_ACTIVE;
               end
            end
            B_ACTIVE: begin
               if (done) begin
                  access <= 1'b0;
                  state  <= B_DROP;
               end
            end
            B_DROP: begin
               pause <= 1'b0;
               fin   <= 1'b1;
               state <= B_IDLE;
            end
            default: state <= B_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/dkong_hiscore_xfer.sv
// High-score restore/save engine for the Donkey Kong core hs port.
// Optional build macro DKONG_HS_CHECKSUM_EN adds a trailing sum byte and a VERIFY pass.
module dkong_hiscore_xfer
   import dkong_hs_pkg::*;
#(
   parameter logic [15:0] START_ADDR  = DEF_START_ADDR,
   parameter int          LENGTH      = DEF_LENGTH,
   parameter logic [15:0] CHECK_ADDR  = DEF_CHECK_ADDR,
   parameter logic [7:0]  CHECK_VAL   = DEF_CHECK_VAL,
   parameter int          WAIT_FRAMES = DEF_WAIT_FRAMES,
   parameter int          GUARD       = DEF_GUARD
)(
   input  logic        I_CLK_24576M,
   input  logic        I_RESET,
   input  logic        I_VBLANK,
   input  logic        I_LOAD_VALID,
   input  logic        I_SAVE_REQ,
   output logic [7:0]  O_BUF_A,
   input  logic [7:0]  I_BUF_DO,
   output logic [7:0]  O_BUF_DI,
   output logic        O_BUF_WE,
   output logic [15:0] O_HS_ADDRESS,
   output logic [7:0]  O_HS_DATA_IN,
   input  logic [7:0]  I_HS_DATA_OUT,
   output logic        O_HS_WRITE,
   output logic        O_HS_ACCESS,
   output logic        O_PAUSE,
   output logic        O_BUSY,
   output logic        O_RESTORED
);

   localparam int         FW         = $clog2(WAIT_FRAMES + 1);
   localparam logic [7:0] LAST_IDX   = 8'(LENGTH - 1);
   localparam logic [1:0] PH_BUF_CAP = 2'(BUF_LAT);
   localparam logic [1:0] PH_HS_CAP  = 2'(HS_LAT);
   localparam logic [1:0] PH_WR      = 2'(BUF_LAT + 1);
   localparam logic [1:0] PH_WE      = 2'(HS_LAT + 1);
`ifdef DKONG_HS_CHECKSUM_EN
   localparam logic [7:0] SUM_IDX    = 8'(LENGTH);
   localparam logic [7:0] LAST_SAVE  = SUM_IDX;
   localparam state_t     LOAD_STATE = VERIFY;
`else
   localparam logic [7:0] LAST_SAVE  = LAST_IDX;
   localparam state_t     LOAD_STATE = RESTORE;
`endif

   state_t          state;
   logic [7:0]      idx;
   logic [1:0]      phase;
   logic [FW-1:0]   frame_cnt;
   logic            vblank_d;
   logic            save_pend;
   logic            launched;
   logic            ending;
   logic            br_start;
   logic            br_done;
   logic            br_fin;
   logic            tick;
`ifdef DKONG_HS_CHECKSUM_EN
   logic [7:0]      sum;
`endif

   assign tick   = I_VBLANK & ~vblank_d;
   assign O_BUSY = (state != IDLE) && (state != READY);

   dkong_hs_bracket #(.GUARD(GUARD)) u_bracket (
      .clk    (I_CLK_24576M),
      .reset  (I_RESET),
      .start  (br_start),
      .done   (br_done),
      .pause  (O_PAUSE),
      .access (O_HS_ACCESS),
      .fin    (br_fin)
   );

   // Each transfer state: launch (init + start bracket), run the byte engine
   // while access is high, then wait for the bracket to release pause.
   always_ff @(posedge I_CLK_24576M) begin
      if (I_RESET) begin
         state        <= IDLE;
         idx          <= '0;
         phase        <= '0;
         frame_cnt    <= '0;
         vblank_d     <= 1'b0;
         save_pend    <= 1'b0;
         launched     <= 1'b0;
         ending       <= 1'b0;
         br_start     <= 1'b0;
         br_done      <= 1'b0;
         O_BUF_A      <= '0;
         O_BUF_DI     <= '0;
         O_BUF_WE     <= 1'b0;
         O_HS_ADDRESS <= '0;
         O_HS_DATA_IN <= '0;
         O_HS_WRITE   <= 1'b0;
         O_RESTORED   <= 1'b0;
`ifdef DKONG_HS_CHECKSUM_EN
         sum          <= '0;
`endif
      end else begin
         vblank_d <= I_VBLANK;
         br_start <= 1'b0;
         br_done  <= 1'b0;
         // NOTE: defaults first; a later non-blocking assignment to the same
         // register in this block overrides them (e.g. READY clears save_pend).
         if (I_SAVE_REQ) save_pend <= 1'b1;

         case (state)
            IDLE: begin
               frame_cnt <= '0;
               state     <= I_LOAD_VALID ? POLL : READY;
            end

            POLL: begin
               if (!launched) begin
                  if (!I_LOAD_VALID) begin
                     state <= IDLE;
                  end else if (tick) begin
                     br_start     <= 1'b1;
                     launched     <= 1'b1;
                     phase        <= '0;
                     O_HS_ADDRESS <= CHECK_ADDR;
                  end
               end else if (O_HS_ACCESS && !ending) begin
                  phase <= phase + 1'b1;
                  if (phase == PH_HS_CAP) begin
                     frame_cnt <= (I_HS_DATA_OUT == CHECK_VAL) ? frame_cnt + 1'b1 : '0;
                     br_done   <= 1'b1;
                     ending    <= 1'b1;
                  end
               end else if (br_fin) begin
                  launched <= 1'b0;
                  ending   <= 1'b0;
                  if (frame_cnt == FW'(WAIT_FRAMES)) state <= LOAD_STATE;
               end
            end

`ifdef DKONG_HS_CHECKSUM_EN
            VERIFY: begin
               if (!launched) begin
                  launched <= 1'b1;
                  idx      <= '0;
                  phase    <= '0;
                  O_BUF_A  <= '0;
                  sum      <= '0;
               end else begin
                  phase <= phase + 1'b1;
                  if (phase == PH_BUF_CAP) begin
                     phase <= '0;
                     if (idx == SUM_IDX) begin
                        launched <= 1'b0;
                        state    <= (I_BUF_DO == sum) ? RESTORE : READY;
                     end else begin
                        sum     <= sum + I_BUF_DO;
                        idx     <= idx + 8'd1;
                        O_BUF_A <= idx + 8'd1;
                     end
                  end
               end
            end
`endif

            RESTORE: begin
               if (!launched) begin
                  br_start <= 1'b1;
                  launched <= 1'b1;
                  idx      <= '0;
                  phase    <= '0;
                  O_BUF_A  <= '0;
               end else if (O_HS_ACCESS && !ending) begin
                  phase <= phase + 1'b1;
                  if (phase == PH_BUF_CAP) begin
                     O_HS_ADDRESS <= hs_addr(START_ADDR, idx);
                     O_HS_DATA_IN <= I_BUF_DO;
                     O_HS_WRITE   <= 1'b1;
                  end else if (phase == PH_WR) begin
                     O_HS_WRITE <= 1'b0;
                     phase      <= '0;
                     if (idx == LAST_IDX) begin
                        br_done <= 1'b1;
                        ending  <= 1'b1;
                     end else begin
                        idx     <= idx + 8'd1;
                        O_BUF_A <= idx + 8'd1;
                     end
                  end
               end else if (br_fin) begin
                  launched   <= 1'b0;
                  ending     <= 1'b0;
                  O_RESTORED <= 1'b1;
                  state      <= READY;
               end
            end

            READY: begin
               if (save_pend || I_SAVE_REQ) begin
                  save_pend <= 1'b0;
                  state     <= SAVE;
               end
            end

            SAVE: begin
               if (!launched) begin
                  br_start     <= 1'b1;
                  launched     <= 1'b1;
                  idx          <= '0;
                  phase        <= '0;
                  O_HS_ADDRESS <= START_ADDR;
`ifdef DKONG_HS_CHECKSUM_EN
                  sum          <= '0;
`endif
               end else if (O_HS_ACCESS && !ending) begin
                  phase <= phase + 1'b1;
                  if (phase == PH_HS_CAP) begin
                     O_BUF_A  <= idx;
                     O_BUF_DI <= I_HS_DATA_OUT;
                     O_BUF_WE <= 1'b1;
`ifdef DKONG_HS_CHECKSUM_EN
                     if (idx == SUM_IDX) O_BUF_DI <= sum;
                     else                sum      <= sum + I_HS_DATA_OUT;
`endif
                  end else if (phase == PH_WE) begin
                     O_BUF_WE <= 1'b0;
                     phase    <= '0;
                     if (idx == LAST_SAVE) begin
                        br_done <= 1'b1;
                        ending  <= 1'b1;
                     end else begin
                        idx          <= idx + 8'd1;
                        O_HS_ADDRESS <= hs_addr(START_ADDR, idx + 8'd1);
                     end
                  end
               end else if (br_fin) begin
                  launched <= 1'b0;
                  ending   <= 1'b0;
                  state    <= READY;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dkong_hiscore_xfer.sv
// Directed bench for dkong_hiscore_xfer with core-RAM and buffer models.
`timescale 1ns/1ps
module tb_dkong_hiscore_xfer;
   import dkong_hs_pkg::*;

`ifdef DKONG_HS_CHECKSUM_EN
   localparam int EXP_WE = 65;
`else
   localparam int EXP_WE = 64;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vblank = 1'b0;
   logic        load_valid = 1'b0;
   logic        save_req = 1'b0;
   logic [7:0]  buf_a, buf_di;
   logic [7:0]  buf_do = 8'h00;
   logic        buf_we;
   logic [15:0] hs_address;
   logic [7:0]  hs_data_in, hs_data_out;
   logic        hs_write, hs_access, pause, busy, restored;

   always #5 clk = ~clk;

   dkong_hiscore_xfer dut (
      .I_CLK_24576M  (clk),
      .I_RESET       (rst),
      .I_VBLANK      (vblank),
      .I_LOAD_VALID  (load_valid),
      .I_SAVE_REQ    (save_req),
      .O_BUF_A       (buf_a),
      .I_BUF_DO      (buf_do),
      .O_BUF_DI      (buf_di),
      .O_BUF_WE      (buf_we),
      .O_HS_ADDRESS  (hs_address),
      .O_HS_DATA_IN  (hs_data_in),
      .I_HS_DATA_OUT (hs_data_out),
      .O_HS_WRITE    (hs_write),
      .O_HS_ACCESS   (hs_access),
      .O_PAUSE       (pause),
      .O_BUSY        (busy),
      .O_RESTORED    (restored)
   );

   // Core RAM (2-cycle read) and external buffer (1-cycle read) models.
   logic [7:0]  ram  [0:65535];
   logic [7:0]  bufm [0:255];
   logic [7:0]  rd1 = 8'h00, rd2 = 8'h00;
   logic        poke_ram = 1'b0, poke_buf = 1'b0, meas_on = 1'b0;
   logic [15:0] poke_a = '0;
   logic [7:0]  poke_d = '0;
   logic        have_prev = 1'b0, pause_d = 1'b0, access_d = 1'b0;
   int          cyc = 0, wr_cnt = 0, we_cnt = 0, gap_bad = 0, viol = 0;
   int          last_we = 0, pause_rise = 0, lead = 0;
   int          total = 0, bad = 0;

   assign hs_data_out = rd2;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      rd1    <= ram[hs_address];
      rd2    <= rd1;
      buf_do <= bufm[buf_a];
      if (poke_ram) ram[poke_a] <= poke_d;
      if (poke_buf) bufm[poke_a[7:0]] <= poke_d;
      if (hs_write && hs_access) ram[hs_address] <= hs_data_in;
      if (hs_write) wr_cnt <= wr_cnt + 1;
      if (hs_write && !hs_access) viol <= viol + 1;
      if (buf_we) begin
         bufm[buf_a] <= buf_di;
         we_cnt      <= we_cnt + 1;
         if (meas_on && have_prev && (cyc - last_we) != 4) gap_bad <= gap_bad + 1;
         last_we   <= cyc;
         have_prev <= meas_on;
      end else if (!meas_on) begin
         have_prev <= 1'b0;
      end
      pause_d  <= pause;
      access_d <= hs_access;
      if (pause && !pause_d) pause_rise <= cyc;
      if (hs_access && !access_d) lead <= cyc - pause_rise;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic is_ram, input logic [15:0] a, input logic [7:0] d);
      poke_a   = a;
      poke_d   = d;
      poke_ram = is_ram;
      poke_buf = !is_ram;
      step(1);
      poke_ram = 1'b0;
      poke_buf = 1'b0;
   endtask

   task automatic frame();
      vblank = 1'b1;
      step(10);
      vblank = 1'b0;
      step(90);
   endtask

   task automatic wait_state(input state_t s, input int max, input string tag);
      int n = 0;
      while (dut.state !== s && n < max) begin step(1); n++; end
      check(tag, 32'(dut.state), 32'(s));
   endtask

   task automatic wait_busy(input logic lvl, input int max, input string tag);
      int n = 0;
      while (busy !== lvl && n < max) begin step(1); n++; end
      check(tag, 32'(busy), 32'(lvl));
   endtask

   task automatic pulse_save();
      save_req = 1'b1;
      step(1);
      save_req = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_pause"},    32'(pause),      0);
      check({tag, "_access"},   32'(hs_access),  0);
      check({tag, "_hs_write"}, 32'(hs_write),   0);
      check({tag, "_hs_addr"},  32'(hs_address), 0);
      check({tag, "_hs_din"},   32'(hs_data_in), 0);
      check({tag, "_buf_we"},   32'(buf_we),     0);
      check({tag, "_buf_a"},    32'(buf_a),      0);
      check({tag, "_buf_di"},   32'(buf_di),     0);
      check({tag, "_restored"}, 32'(restored),   0);
      check({tag, "_busy"},     32'(busy),       0);
      check({tag, "_state"},    32'(dut.state),  32'(IDLE));
   endtask

   initial begin
      int         wr_base, we_base, gap_base, n;
      logic [7:0] sum;

      // Reset with a saved table i^5A in the buffer and the check byte at 00.
      step(2);
      sum = 8'h00;
      for (int i = 0; i < 64; i++) begin
         poke(1'b0, 16'(i), 8'(i) ^ 8'h5A);
         sum = sum + (8'(i) ^ 8'h5A);
      end
`ifdef DKONG_HS_CHECKSUM_EN
      poke(1'b0, 16'd64, sum);
`endif
      poke(1'b1, 16'h611C, 8'h00);
      load_valid = 1'b1;
      @(negedge clk);
      check_outputs_zero("reset");
      step(1);

      // Three matching frames, one mismatch, then three more: still polling.
      rst = 1'b0;
      step(2);
      check("enter_poll", 32'(dut.state), 32'(POLL));
      repeat (3) frame();
      poke(1'b1, 16'h611C, 8'h01);
      frame();
      poke(1'b1, 16'h611C, 8'h00);
      repeat (3) frame();
      check("no_early_restore_state", 32'(dut.state), 32'(POLL));
      check("no_early_restore_writes", 32'(wr_cnt), 0);
      check("no_early_restored", 32'(restored), 0);

      // Fourth matching frame of the run starts the restore.
      vblank = 1'b1;
      wait_state(RESTORE, 400, "reach_restore");
      vblank = 1'b0;
      step(20);
      pulse_save();
      step(20);
      pulse_save();
      we_base = we_cnt;
      n = 0;
      while (restored !== 1'b1 && n < 400) begin step(1); n++; end
      check("restored_set", 32'(restored), 1);
      check("restore_writes", 32'(wr_cnt), 64);
      check("pause_lead", 32'(lead), 8);
      check("write_outside_access", 32'(viol), 0);
      for (int i = 0; i < 64; i++)
         check($sformatf("ram_%0h", 16'h6100 + i), 32'(ram[16'h6100 + i]), 32'(8'(i) ^ 8'h5A));

      // The two latched requests produce exactly one save.
      step(5);
      wait_busy(1'b0, 400, "pending_save_done");
      check("pending_save_we", 32'(we_cnt - we_base), EXP_WE);
      step(400);
      check("single_save_we", 32'(we_cnt - we_base), EXP_WE);
      check("ready_after_save", 32'(dut.state), 32'(READY));

      // Save from READY with RAM 6100+i = i.
      for (int i = 0; i < 64; i++) poke(1'b1, 16'h6100 + 16'(i), 8'(i));
      meas_on  = 1'b1;
      we_base  = we_cnt;
      gap_base = gap_bad;
      pulse_save();
      wait_busy(1'b1, 10, "save_busy");
      wait_busy(1'b0, 400, "save_done");
      meas_on = 1'b0;
      check("save_we_count", 32'(we_cnt - we_base), EXP_WE);
      check("save_we_spacing", 32'(gap_bad - gap_base), 0);
      check("save_no_hs_write", 32'(wr_cnt), 64);
      for (int i = 0; i < 64; i++)
         check($sformatf("buf_%0d", i), 32'(bufm[i]), i);
`ifdef DKONG_HS_CHECKSUM_EN
      check("buf_sum", 32'(bufm[64]), 32'h0E0);
`endif

      // Reset while byte 10 of a save is in flight.
      we_base = we_cnt;
      pulse_save();
      n = 0;
      while ((we_cnt - we_base) < 10 && n < 200) begin step(1); n++; end
      check("reach_byte10", 32'(we_cnt - we_base), 10);
      check("byte10_pause", 32'(pause), 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_outputs_zero("midsave_reset");
      step(1);

`ifdef DKONG_HS_CHECKSUM_EN
      // Corrupted sum byte: verify fails, nothing is written to core RAM.
      poke(1'b0, 16'd64, sum ^ 8'hFF);
      poke(1'b1, 16'h611C, 8'h00);
      load_valid = 1'b1;
      wr_base = wr_cnt;
      rst = 1'b0;
      repeat (6) frame();
      check("bad_sum_no_writes", 32'(wr_cnt - wr_base), 0);
      check("bad_sum_not_restored", 32'(restored), 0);
      check("bad_sum_ready", 32'(dut.state), 32'(READY));
`else
      // Without a saved table the block goes straight to READY.
      load_valid = 1'b0;
      wr_base = wr_cnt;
      rst = 1'b0;
      step(3);
      check("noload_ready", 32'(dut.state), 32'(READY));
      check("noload_no_writes", 32'(wr_cnt - wr_base), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dkong_hiscore_xfer.md
Name: dkong_hiscore_xfer

Overview:
- Upstream companion of the Donkey Kong core top; sole driver of its hs_address / hs_data_in / hs_write / hs_access and pause inputs.
- Restores a high-score table from an external byte buffer into core RAM once the game has initialised that table.
- On request, copies the table from core RAM back to the buffer.
- Pauses the Z80 around every access so the shared RAM port is never contended.

Parameters:
- START_ADDR, 16'h6100, first core address of the table (RAM1 window 0x6000-0x67FF)
- LENGTH, 64, table size in bytes, 1..256
- CHECK_ADDR, 16'h611C, core address polled to detect table initialisation
- CHECK_VAL, 8'h00, value at CHECK_ADDR meaning "initialised"
- WAIT_FRAMES, 4, frames the check must hold before restore
- GUARD, 8, cycles between pause assertion and first hs_access

Ports:
- I_CLK_24576M  in  1  single clock for the block
- I_RESET  in  1  synchronous, active-high reset
- I_VBLANK  in  1  core vertical blank (active high); frame tick = rising edge
- I_LOAD_VALID  in  1  level; external buffer holds a saved table
- I_SAVE_REQ  in  1  one-cycle pulse; request a save
- O_BUF_A  out  8  buffer byte address
- I_BUF_DO  in  8  buffer read data, 1-cycle latency
- O_BUF_DI  out  8  buffer write data
- O_BUF_WE  out  1  buffer write strobe
- O_HS_ADDRESS  out  16  to core hs_address
- O_HS_DATA_IN  out  8  to core hs_data_in
- I_HS_DATA_OUT  in  8  from core hs_data_out, 2-cycle latency
- O_HS_WRITE  out  1  to core hs_write
- O_HS_ACCESS  out  1  to core hs_access
- O_PAUSE  out  1  to core pause
- O_BUSY  out  1  high in any state except IDLE/READY
- O_RESTORED  out  1  sticky; restore completed

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, O_RESTORED 0. Reset mid-transfer aborts immediately; partial RAM writes are not rolled back.
- States and transitions:
  - IDLE: if I_LOAD_VALID, go to POLL; otherwise go to READY.
  - POLL: on each frame tick, pause, then read CHECK_ADDR. Match increments the frame counter; mismatch clears it. Counter reaching WAIT_FRAMES goes to RESTORE.
  - RESTORE: copy LENGTH bytes, buffer[i] -> START_ADDR+i, then set O_RESTORED and go to READY.
  - READY: on I_SAVE_REQ, go to SAVE.
  - SAVE: copy START_ADDR+i -> buffer[i], then return to READY.
- I_SAVE_REQ arriving outside READY is latched. It is served upon entering READY, with one pending request maximum. It is cleared by reset.
- Access bracket, common to poll, restore and save:
  - Assert O_PAUSE.
  - Wait GUARD cycles, then assert O_HS_ACCESS for the whole transfer.
  - On completion, drop O_HS_ACCESS, then drop O_PAUSE one cycle later.
- Restore byte timing: 3 cycles per byte.
  - Cycle 0: present O_BUF_A=i.
  - Cycle 1: data is valid.
  - Cycle 2: drive O_HS_ADDRESS and O_HS_DATA_IN, with O_HS_WRITE=1 for exactly 1 cycle.
- Save byte timing: 4 cycles per byte.
  - Cycle 0: drive O_HS_ADDRESS.
  - Cycle 2: data is valid.
  - Cycle 3: O_BUF_WE=1 with O_BUF_A=i and O_BUF_DI=data.
- Poll read uses the same 2-cycle latency as a save read; O_HS_WRITE stays 0.
- O_HS_WRITE is never high while O_HS_ACCESS is low.
- Byte index is 8-bit. Address = START_ADDR + index, 16-bit, no wrap. The last byte is index LENGTH-1.
- I_LOAD_VALID falling during POLL returns the block to IDLE. It is ignored once RESTORE has begun.

Optional Feature:
- DKONG_HS_CHECKSUM_EN: buffer holds LENGTH+1 bytes; byte LENGTH is the 8-bit additive sum of bytes 0..LENGTH-1.
  - Restore first runs a VERIFY pass reading the buffer only, with no pause.
  - On mismatch, skip restore: go to READY with O_RESTORED=0.
  - Save writes the sum as a final extra byte.
- Without the macro: buffer holds LENGTH bytes and there is no VERIFY state.

Decomposition:
- Package dkong_hs_pkg holds:
  - state enum: IDLE, POLL, VERIFY, RESTORE, READY, SAVE;
  - latency constants: BUF_LAT=1, HS_LAT=2;
  - the default table constants.
- One natural sub-module, dkong_hs_bracket: the pause/guard/access sequencer with start/done handshake, shared by all transfer states.

Test Plan:
- Reset during SAVE byte 10: all outputs 0 the next cycle, state IDLE, O_BUSY=0.
- I_LOAD_VALID=1, RAM[611C]=00 held for 4 frames, buffer=i^8'h5A:
  - RAM 6100..613F equals the buffer after 4 frames.
  - O_RESTORED=1.
  - O_PAUSE leads O_HS_ACCESS by 8 cycles.
- RAM[611C]=00 for 3 frames, then 01, then 00 for 4 frames: restore starts only after the second run completes (counter cleared by the mismatch).
- Save in READY with RAM 6100+i=i: buffer[0..63]=0..63, with 64 O_BUF_WE pulses spaced 4 cycles apart.
- I_SAVE_REQ pulsed twice during RESTORE: exactly one save executes after RESTORE completes.
- With DKONG_HS_CHECKSUM_EN and a corrupted buffer byte 64: no O_HS_WRITE pulses, and O_RESTORED stays 0.
